// File: rtl/mux8_rr_tx_if.sv
`default_nettype none
// ============================================================================
// mux8_rr_tx_if : handshake bundle between eight sources, the round-robin mux
//                 and the downstream consumer
// Revision      : 1.0
// ============================================================================
interface mux8_rr_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
);
  logic                 en;
  logic [8*WIDTH-1:0]   in_data;
  logic [7:0]           in_valid;
  logic [7:0]           in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [2:0]           out_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNTW-1:0]      out_count;

  // Environment side: drives sources, enable and downstream ready.
  modport master (
    output en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid, out_count
  );

  // Multiplexer side.
  modport slave (
    input  en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid, out_count
  );
endinterface
`default_nettype wire

// File: rtl/mux8_rr_tx.sv
`default_nettype none
// ============================================================================
// mux8_rr_tx : 8-to-1 round-robin mux with registered output word, 3-bit
//              source tag and delivered-word counter
// Revision   : 1.0
// ============================================================================
module mux8_rr_tx #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input logic         clk,
  input logic         rst,
  mux8_rr_tx_if.slave bus
);

  logic [WIDTH-1:0] chan [8];
  logic [2:0]       grant_idx;
  logic             has_req;
  logic             load_ok;
  logic             xfer;
  logic [7:0]       in_ready_w;

  logic [WIDTH-1:0] out_data_d,  out_data_q;
  logic [2:0]       out_sel_d,   out_sel_q;
  logic             out_valid_d, out_valid_q;
  logic [2:0]       ptr_d,       ptr_q;
  logic [CNTW-1:0]  count_d,     count_q;

  for (genvar i = 0; i < 8; i++) begin : g_chan
    assign chan[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  // Search starts at ptr and wraps, so the channel after the last winner has top priority.
  always_comb begin : p_grant
    logic [2:0] cand;
    logic       found;
    grant_idx = 3'd0;
    found     = 1'b0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && bus.in_valid[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  assign has_req    = |bus.in_valid;
  assign load_ok    = bus.en & (~out_valid_q | bus.out_ready);
  assign xfer       = load_ok & has_req & ~rst;
  assign in_ready_w = xfer ? (8'd1 << grant_idx) : 8'd0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    count_d     = count_q;

    if (out_valid_q && bus.out_ready) begin
      count_d = count_q + CNTW'(1);
    end

    // A load in the same cycle as a drain replaces the word with no bubble.
    if (xfer) begin
      out_data_d  = chan[grant_idx];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = grant_idx + 3'd1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= 3'd0;
      out_valid_q <= 1'b0;
      ptr_q       <= 3'd0;
      count_q     <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_tx.sv
`default_nettype none
// ============================================================================
// tb_mux8_rr_tx : directed bench for mux8_rr_tx with a per-cycle reference model
// Revision      : 1.0
// ============================================================================
module tb_mux8_rr_tx;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mux8_rr_tx_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  mux8_rr_tx #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what the output register and pointer must hold.
  int m_valid = 0;
  int m_data  = 0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  function automatic int pick(input int ptr, input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  function automatic int exp_ready();
    int g;
    g = pick(m_ptr, bus.in_valid);
    if (rst || !bus.en || !((m_valid == 0) || bus.out_ready) || g < 0) return 0;
    return 1 << g;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int g;
    int ld;
    if (rst) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      g  = pick(m_ptr, bus.in_valid);
      ld = (bus.en && ((m_valid == 0) || bus.out_ready) && g >= 0) ? 1 : 0;
      if (m_valid != 0 && bus.out_ready) m_cnt = (m_cnt + 1) % (1 << CNTW);
      if (ld != 0) begin
        m_data  = int'(bus.in_data[g*WIDTH +: WIDTH]);
        m_sel   = g;
        m_valid = 1;
        m_ptr   = (g + 1) % 8;
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model in_ready",  int'(bus.in_ready),  exp_ready());
    chk("model out_valid", int'(bus.out_valid), m_valid);
    chk("model out_data",  int'(bus.out_data),  m_data);
    chk("model out_sel",   int'(bus.out_sel),   m_sel);
    chk("model out_count", int'(bus.out_count), m_cnt);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int base, input int step);
    for (int i = 0; i < 8; i++) bus.in_data[i*WIDTH +: WIDTH] = 8'(base + step * i);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.in_valid = 8'h00;
    bus.out_ready = 1'b0;
    bus.in_data = '0;

    // Reset then idle
    cyc(2);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_count", int'(bus.out_count), 0);
    chk("rst in_ready",  int'(bus.in_ready),  0);
    rst = 1'b0;
    cyc(2);
    chk("idle out_valid", int'(bus.out_valid), 0);
    chk("idle in_ready",  int'(bus.in_ready),  0);

    // Single channel 5
    bus.en = 1'b1; bus.out_ready = 1'b1;
    bus.in_data[5*WIDTH +: WIDTH] = 8'hA5;
    bus.in_valid = 8'h20;
    #1 chk("single in_ready", int'(bus.in_ready), 8'h20);
    cyc();
    bus.in_valid = 8'h00;
    chk("single out_data",  int'(bus.out_data),  8'hA5);
    chk("single out_sel",   int'(bus.out_sel),   5);
    chk("single out_valid", int'(bus.out_valid), 1);
    cyc();
    chk("single out_count", int'(bus.out_count), 1);
    chk("single drained",   int'(bus.out_valid), 0);
    bus.in_valid = 8'h41;
    #1 chk("ptr=6 grant", int'(bus.in_ready), 8'h40);
    cyc();
    bus.in_valid = 8'h00;
    chk("ptr=6 out_sel", int'(bus.out_sel), 6);
    cyc();

    // Full round robin after a clean reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_data(8'h10, 1);
    bus.in_valid = 8'hFF;
    for (int w = 0; w < 10; w++) begin
      cyc();
      chk("rr out_sel",  int'(bus.out_sel),  w % 8);
      chk("rr out_data", int'(bus.out_data), 8'h10 + (w % 8));
    end
    chk("rr count presented", int'(bus.out_count), 9);
    bus.in_valid = 8'h00;
    cyc();
    chk("rr count accepted", int'(bus.out_count), 10);

    // Backpressure holding ch3
    set_data(0, 8'h11);
    bus.out_ready = 1'b0;
    bus.in_valid = 8'h08;
    cyc();
    bus.in_valid = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp in_ready", int'(bus.in_ready), 0);
      chk("bp out_data", int'(bus.out_data), 8'h33);
      chk("bp out_sel",  int'(bus.out_sel),  3);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp release grant", int'(bus.in_ready), 8'h10);
    cyc();
    bus.in_valid = 8'h00;
    chk("bp next out_sel", int'(bus.out_sel), 4);
    chk("bp count", int'(bus.out_count), 11);
    cyc();
    chk("bp count2", int'(bus.out_count), 12);

    // Enable gating with a held ch2 word
    bus.out_ready = 1'b0;
    bus.in_valid = 8'h04;
    cyc();
    bus.en = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 8'h01;
    #1 chk("en0 in_ready", int'(bus.in_ready), 0);
    cyc();
    chk("en0 drained",   int'(bus.out_valid), 0);
    chk("en0 out_count", int'(bus.out_count), 13);
    chk("en0 no grant",  int'(bus.in_ready),  0);
    bus.en = 1'b1;
    #1 chk("en1 grant ch0", int'(bus.in_ready), 8'h01);
    cyc();
    bus.in_valid = 8'h00;
    chk("en1 out_sel", int'(bus.out_sel), 0);
    cyc();
    chk("en1 count", int'(bus.out_count), 14);

    // Counter wrap at 16 transfers since reset
    bus.in_valid = 8'hFF;
    cyc(2);
    bus.in_valid = 8'h00;
    cyc();
    chk("wrap count", int'(bus.out_count), 0);

    // Reset with a pending word
    bus.in_valid = 8'hFF;
    cyc(2);
    bus.out_ready = 1'b0;
    #1;
    chk("pre-rst valid", int'(bus.out_valid), 1);
    chk("pre-rst count", int'(bus.out_count), 1);
    rst = 1'b1;
    #1 chk("rst in_ready", int'(bus.in_ready), 0);
    cyc();
    chk("mid-rst out_valid", int'(bus.out_valid), 0);
    chk("mid-rst out_count", int'(bus.out_count), 0);
    rst = 1'b0; bus.out_ready = 1'b1;
    #1 chk("post-rst grant", int'(bus.in_ready), 8'h01);
    cyc();
    chk("post-rst out_sel", int'(bus.out_sel), 0);
    bus.in_valid = 8'h00;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
